gs_bfu: RTL

//  Gentleman-Sande (DIF) butterfly, the inverse-direction partner of the DIT

---
 rtl/gs_bfu.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gs_bfu.sv
// gs_bfu: Gentleman-Sande (DIF) butterfly for the inverse-FFT datapath.
//   A_o = A + B           (Q15, saturated per lane)
//   B_o = (A - B) * w     (Q15, rounded half up and saturated per lane)
// Operands are packed complex Q15 {re[31:16], im[15:0]}.
// Four register stages advance together on adv = !out_valid || out_ready.
// Each stage carries a valid bit, so bubbles flow through as invalid slots.
// Optional build macro GS_BFU_HALVE_EN: the first stage halves A+B and A-B
// with an arithmetic floor shift instead of saturating them. This provides
// the per-stage 1/2 scaling used by the inverse transform.
module gs_bfu #(
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      A,
   input  logic [31:0]      B,
   input  logic [31:0]      w,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      A_o,
   output logic [31:0]      B_o,
   output logic [TAG_W-1:0] tag_out
);

   // Clamp a 17-bit lane sum or difference into the Q15 range.
   function automatic logic [15:0] sat17(input logic signed [16:0] x);
      if (x[16] != x[15]) begin
         sat17 = x[16] ? 16'h8000 : 16'h7FFF;
      end else begin
         sat17 = x[15:0];
      end
   endfunction

   // Turn a Q30 lane into Q15: add half an LSB, floor-shift, then clamp.
   function automatic logic [15:0] rndSat(input logic signed [32:0] x);
      logic signed [32:0] biased;
      logic signed [18:0] shifted;
      biased  = x + 33'sd16384;
      shifted = 19'(biased >>> 15);
      if (shifted > 19'sd32767) begin
         rndSat = 16'h7FFF;
      end else if (shifted < -19'sd32768) begin
         rndSat = 16'h8000;
      end else begin
         rndSat = shifted[15:0];
      end
   endfunction

   logic adv;

   // Stage 1: lane sum and difference, twiddle and tag.
   logic             v1_q;
   logic [31:0]      sum1_q, sum1_d;
   logic [31:0]      dif1_q, dif1_d;
   logic [31:0]      w1_q;
   logic [TAG_W-1:0] tag1_q;

   // Stage 2: the four partial products.
   logic                v2_q;
   logic [31:0]         sum2_q;
   logic [TAG_W-1:0]    tag2_q;
   logic signed [31:0]  pRR_q, pII_q, pRI_q, pIR_q;
   logic signed [31:0]  pRR_d, pII_d, pRI_d, pIR_d;

   // Stage 3: the complex product in Q30.
   logic                v3_q;
   logic [31:0]         sum3_q;
   logic [TAG_W-1:0]    tag3_q;
   logic signed [32:0]  re3_q, im3_q;
   logic signed [32:0]  re3_d, im3_d;

   // Stage 4: the registered outputs.
   logic             outValid_q;
   logic [31:0]      aOut_q;
   logic [31:0]      bOut_q, bOut_d;
   logic [TAG_W-1:0] tagOut_q;

   logic signed [16:0] sumRe, sumIm, difRe, difIm;

   assign adv       = !outValid_q || out_ready;
   assign in_ready  = rst_n && adv;
   assign out_valid = outValid_q;
   assign A_o       = aOut_q;
   assign B_o       = bOut_q;
   assign tag_out   = tagOut_q;

   // Stage 1 arithmetic: 17-bit lane add/subtract, then halve or saturate.
   always_comb begin
      sumRe = 17'($signed(A[31:16])) + 17'($signed(B[31:16]));
      sumIm = 17'($signed(A[15:0]))  + 17'($signed(B[15:0]));
      difRe = 17'($signed(A[31:16])) - 17'($signed(B[31:16]));
      difIm = 17'($signed(A[15:0]))  - 17'($signed(B[15:0]));
`ifdef GS_BFU_HALVE_EN
      sum1_d = {sumRe[16:1], sumIm[16:1]};
      dif1_d = {difRe[16:1], difIm[16:1]};
`else
      sum1_d = {sat17(sumRe), sat17(sumIm)};
      dif1_d = {sat17(difRe), sat17(difIm)};
`endif
   end

   // Stage 2 arithmetic: signed 16x16 products of the difference and the twiddle.
   always_comb begin
      pRR_d = $signed(dif1_q[31:16]) * $signed(w1_q[31:16]);
      pII_d = $signed(dif1_q[15:0])  * $signed(w1_q[15:0]);
      pRI_d = $signed(dif1_q[31:16]) * $signed(w1_q[15:0]);
      pIR_d = $signed(dif1_q[15:0])  * $signed(w1_q[31:16]);
   end

   // Stage 3 and stage 4 arithmetic: combine the products, then round into Q15.
   always_comb begin
      re3_d  = 33'(pRR_q) - 33'(pII_q);
      im3_d  = 33'(pRI_q) + 33'(pIR_q);
      bOut_d = {rndSat(re3_q), rndSat(im3_q)};
   end

   // Pipeline registers: every stage shifts on adv and holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q       <= 1'b0;
         sum1_q     <= '0;
         dif1_q     <= '0;
         w1_q       <= '0;
         tag1_q     <= '0;
         v2_q       <= 1'b0;
         sum2_q     <= '0;
         tag2_q     <= '0;
         pRR_q      <= '0;
         pII_q      <= '0;
         pRI_q      <= '0;
         pIR_q      <= '0;
         v3_q       <= 1'b0;
         sum3_q     <= '0;
         tag3_q     <= '0;
         re3_q      <= '0;
         im3_q      <= '0;
         outValid_q <= 1'b0;
         aOut_q     <= '0;
         bOut_q     <= '0;
         tagOut_q   <= '0;
      end else if (adv) begin
         v1_q       <= in_valid;
         sum1_q     <= sum1_d;
         dif1_q     <= dif1_d;
         w1_q       <= w;
         tag1_q     <= tag_in;
         v2_q       <= v1_q;
         sum2_q     <= sum1_q;
         tag2_q     <= tag1_q;
         pRR_q      <= pRR_d;
         pII_q      <= pII_d;
         pRI_q      <= pRI_d;
         pIR_q      <= pIR_d;
         v3_q       <= v2_q;
         sum3_q     <= sum2_q;
         tag3_q     <= tag2_q;
         re3_q      <= re3_d;
         im3_q      <= im3_d;
         outValid_q <= v3_q;
         aOut_q     <= sum3_q;
         bOut_q     <= bOut_d;
         tagOut_q   <= tag3_q;
      end
   end

endmodule
